// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the button conditioner (channel FSM states,
// per-channel event bundle, counter width helper).
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic step;
  } btn_ev_t;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional auto-repeat
// timer (compiled in when BTN_AUTOREPEAT_EN is defined).
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  output btn_ev_t ev
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1, s2;
  btn_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic press_d, rel_d;
  logic level_q, press_q, rel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= (ACTIVE_LOW != 0) ? ~raw : raw;
      s2 <= s1;
    end
  end

  // The entry edge into a WAIT state counts as the first stable sample, so a
  // change is accepted after DEBOUNCE_CYCLES further stable edges.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state)
      IDLE: if (s2) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
      HELD: if (!s2) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      level_q <= (state_d == HELD) || (state_d == RELEASE_WAIT);
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int TW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [TW-1:0] rtmr, rtmr_d;
  logic rep_d, rep_q;

  // Down-counter reloaded on the press edge; leaving to IDLE wins over a due repeat.
  always_comb begin
    rtmr_d = rtmr;
    rep_d  = 1'b0;
    if (press_d) begin
      rtmr_d = TW'(REPEAT_DELAY - 1);
    end else if (state_d == IDLE) begin
      rtmr_d = '0;
    end else if ((state == HELD) || (state == RELEASE_WAIT)) begin
      if (rtmr == '0) begin
        rep_d  = 1'b1;
        rtmr_d = TW'(REPEAT_PERIOD - 1);
      end else begin
        rtmr_d = rtmr - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rtmr  <= '0;
      rep_q <= 1'b0;
    end else begin
      rtmr  <= rtmr_d;
      rep_q <= rep_d;
    end
  end

  assign ev.step = press_q | rep_q;
`else
  // Repeat parameters have no effect in this build; they only appear here.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_cfg_unused
  end

  assign ev.step = press_q;
`endif

  assign ev.level = level_q;
  assign ev.press = press_q;
  assign ev.rel   = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounced button channels with press/release/step pulses;
// auto-repeat on btn_step when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  btn_ev_t [N_BTN-1:0] ev;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(btn_raw[i]),
      .ev (ev[i])
    );

    assign btn_level[i]   = ev[i].level;
    assign btn_press[i]   = ev[i].press;
    assign btn_release[i] = ev[i].rel;
    assign btn_step[i]    = ev[i].step;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboarded random/directed bench for btn_conditioner against a run-length
// reference model; honours BTN_AUTOREPEAT_EN like the design.
module tb_btn_conditioner;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_step;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW     (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step)
  );

  typedef struct {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] step;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: a level change is accepted once the synchronized input
  // (raw from two edges earlier) has disagreed with the accepted level on
  // D+1 consecutive edges. Repeats follow from the age of the press.
  logic [N-1:0] raw_log[$];
  int           since_rst = 0;
  int           run[N];
  logic         lvl[N];
  int           age[N];

  task automatic model_edge(input logic r, input logic [N-1:0] raw, output exp_t e);
    logic [N-1:0] s;
    logic rep;
    e.level = '0; e.press = '0; e.rel = '0; e.step = '0;
    if (r) begin
      raw_log.delete();
      since_rst = 0;
      for (int c = 0; c < N; c++) begin
        run[c] = 0; lvl[c] = 1'b0; age[c] = 0;
      end
      return;
    end
    raw_log.push_back(raw);
    s = (since_rst >= 2) ? raw_log[raw_log.size()-3] : '0;
    if (raw_log.size() > 3) void'(raw_log.pop_front());
    since_rst++;
    for (int c = 0; c < N; c++) begin
      if (s[c] != lvl[c]) run[c]++;
      else run[c] = 0;
      if (run[c] == D + 1) begin
        lvl[c] = ~lvl[c];
        run[c] = 0;
        if (lvl[c]) e.press[c] = 1'b1;
        else        e.rel[c]   = 1'b1;
      end
      rep = 1'b0;
      if (e.press[c]) age[c] = 0;
      else if (lvl[c]) begin
        age[c]++;
        rep = (age[c] == RD) || ((age[c] > RD) && ((age[c] - RD) % RP == 0));
      end
`ifdef BTN_AUTOREPEAT_EN
      e.step[c] = e.press[c] | rep;
`else
      e.step[c] = e.press[c];
`endif
      e.level[c] = lvl[c];
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] raw);
    exp_t e;
    @(negedge clk);
    rst = r;
    btn_raw = raw;
    model_edge(r, raw, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, raw);
  endtask

  // Monitor: outputs are valid every cycle, compared just after each edge.
  exp_t got_e;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      total++;
      if (btn_level !== got_e.level || btn_press !== got_e.press ||
          btn_release !== got_e.rel || btn_step !== got_e.step) begin
        bad++;
        $display("FAIL outputs cyc=%0d lvl/prs/rel/stp got %b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, btn_level, btn_press, btn_release, btn_step,
                 got_e.level, got_e.press, got_e.rel, got_e.step);
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    int           div;
    for (int i = 0; i < 3; i++) drive(1'b1, '0);
    hold(2'b00, 7);
    // clean press on ch0, then release with a short bounce back to pressed
    hold(2'b01, 30);
    hold(2'b00, 2);
    hold(2'b01, 2);
    hold(2'b00, 15);
    // glitch train too short to be accepted
    for (int i = 0; i < 10; i++) begin
      hold(2'b01, 3);
      hold(2'b00, 2);
    end
    hold(2'b00, 10);
    // long hold on ch1 (auto-repeat window)
    hold(2'b10, 60);
    hold(2'b00, 15);
    // simultaneous press, reset mid-hold, re-press after reset
    hold(2'b11, 15);
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b11);
    hold(2'b11, 15);
    hold(2'b00, 15);
    // random phases alternating bouncy and long-hold behaviour
    cur = '0;
    for (int seg = 0; seg < 6; seg++) begin
      div = (seg % 2 != 0) ? 60 : 6;
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(div - 1, 0) == 0) cur[c] = ~cur[c];
        drive(($urandom_range(299, 0) == 0), cur);
      end
    end
    hold(2'b00, 20);
    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 2, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a level change; legal range 1..2^24-1.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles from press pulse to first repeat pulse; must be ≥1.
REQ-004 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent repeat pulses; must be ≥1.
REQ-005 Parameter ACTIVE_LOW, default 0; when 1, raw input low means pressed.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 btn_raw  input  N_BTN  asynchronous raw button levels.
REQ-009 btn_level  output  N_BTN  debounced pressed level, 1 = pressed.
REQ-010 btn_press  output  N_BTN  one-cycle pulse on accepted press.
REQ-011 btn_release  output  N_BTN  one-cycle pulse on accepted release.
REQ-012 btn_step  output  N_BTN  one-cycle pulse = press OR auto-repeat; drives the downstream display counter's increment/speed inputs.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer, inverted first when ACTIVE_LOW=1.
REQ-014 Per channel FSM SHALL have states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE -> PRESS_WAIT when synced input=1; PRESS_WAIT counts consecutive synced-1 cycles; synced 0 returns to IDLE and clears the count.
REQ-016 PRESS_WAIT -> HELD when count reaches DEBOUNCE_CYCLES; on that edge btn_level rises and btn_press and btn_step pulse for exactly one cycle.
REQ-017 Latency: raw held pressed from sampling edge k SHALL give btn_press high in the cycle after edge k+2+DEBOUNCE_CYCLES; shorter glitches produce no output.
REQ-018 HELD -> RELEASE_WAIT when synced input=0; RELEASE_WAIT returns to HELD on synced 1 (count cleared), or -> IDLE after DEBOUNCE_CYCLES consecutive 0s, dropping btn_level and pulsing btn_release one cycle.
REQ-019 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter saturates, never wraps.
REQ-020 Channels are fully independent; simultaneous presses on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 btn_press and btn_release on a channel are never high in the same cycle.

Reset
REQ-022 rst=1 SHALL force all FSMs to IDLE, clear synchronizers, counters and repeat timers; btn_level, btn_press, btn_release, btn_step all 0 the cycle after.
REQ-023 A button held through reset deassertion SHALL be treated as a new press and debounced in full; no release pulse is generated for the interrupted press.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN: when defined, in HELD a repeat timer starts at the press pulse; btn_step pulses REPEAT_DELAY cycles after btn_press, then every REPEAT_PERIOD cycles while in HELD or RELEASE_WAIT.
REQ-025 A transition to IDLE SHALL cancel the repeat timer immediately; a repeat due on the same edge as release acceptance is suppressed.
REQ-026 Without BTN_AUTOREPEAT_EN: btn_step equals btn_press exactly; no repeat timer logic synthesized; REPEAT_* parameters ignored.

Structure
REQ-027 Package btn_cond_pkg SHALL hold the FSM state enum (2-bit encoding) and a clog2-based width helper constant function.
REQ-028 Sub-module btn_debounce_ch SHALL implement one channel (synchronizer, FSM, counters); top level generates N_BTN instances.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, N_BTN=2)
REQ-029 Raw ch0 held 1 from edge 10 -> btn_press[0] and btn_step[0] high only in the cycle after edge 16, btn_level[0]=1 thereafter.
REQ-030 Raw ch0 pulses of 3 cycles separated by 2 cycles of 0, repeated 10 times -> no btn_press, btn_level stays 0.
REQ-031 Press ch1 held 60 cycles with BTN_AUTOREPEAT_EN -> btn_step[1] at press, +20, +28, +36, ...; without macro -> single btn_step.
REQ-032 Press then raw release with a 2-cycle bounce back to 1 -> release accepted only after 4 clean 0s, single btn_release pulse.
REQ-033 Both channels pressed on same edge -> btn_press=2'b11 in one cycle; assert rst mid-HELD -> outputs 0 next cycle, re-press detected after 6 cycles with rst low.
